// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer: state
// encoding, opcode/funccode values and the select encodings for the bus
// address and the PC source.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_t;

  // Primary opcodes (IW[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LWR    = 6'b100110;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type function codes (IW[5:0]) that do not write the register file
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_MTHI   = 6'b010001;
  localparam logic [5:0] FN_MTLO   = 6'b010011;
  localparam logic [5:0] FN_MULT   = 6'b011000;
  localparam logic [5:0] FN_DIVU   = 6'b011011;

  // REGIMM rt field values for the linking branches
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // PC source select
  localparam logic PC_SRC_SEQ    = 1'b0;  // PC + 4
  localparam logic PC_SRC_TARGET = 1'b1;  // latched branch/jump target

  // Bus address select
  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

endpackage : mips_cpu_pkg

// File: rtl/mips_cpu_ctrl_class.sv
// Combinational instruction classifier: tells the sequencer whether the
// latched instruction needs a data-memory phase and/or a register write-back.
module mips_cpu_ctrl_class
  import mips_cpu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funccode,
  input  logic [4:0] i_rt,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_writes_reg
);

  // Decode memory class and write-back need from the instruction fields
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave one unassigned and infer a latch.
    o_is_load    = (i_opcode >= OP_LB) && (i_opcode <= OP_LWR);
    o_is_store   = (i_opcode == OP_SB) || (i_opcode == OP_SH) || (i_opcode == OP_SW);
    o_writes_reg = 1'b0;

    case (i_opcode)
      OP_RTYPE: begin
        // HI/LO movers, multiply/divide and JR leave the register file alone
        o_writes_reg = !((i_funccode == FN_JR)   ||
                         (i_funccode == FN_MTHI) ||
                         (i_funccode == FN_MTLO) ||
                         ((i_funccode >= FN_MULT) && (i_funccode <= FN_DIVU)));
      end
      OP_REGIMM: begin
        // Linking branches write $ra whether or not the branch is taken
        o_writes_reg = (i_rt == RT_BLTZAL) || (i_rt == RT_BGEZAL);
      end
      OP_JAL: begin
        o_writes_reg = 1'b1;
      end
      default: begin
        o_writes_reg = (i_opcode >= OP_ADDIU) && (i_opcode <= OP_LUI);
      end
    endcase
  end

endmodule : mips_cpu_ctrl_class

// File: rtl/mips_cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, runs the memory-bus handshake, produces the
// IR/PC/register-file strobes and tracks the branch delay slot.
module mips_cpu_ctrl_fsm
  import mips_cpu_pkg::*;
#(
  // Informational; the PC register owns the real reset value.
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       waitrequest,
  input  logic       pc_is_zero,
  input  logic [5:0] opcode,
  input  logic [5:0] funccode,
  input  logic [4:0] rt,
  input  logic       is_branch,
  input  logic       is_jump,
  input  logic       cond_met,
  output logic [2:0] state,
  output logic       active,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       target_load,
  output logic       reg_write
);

  // A misaligned reset vector would fetch garbage forever; reject it early.
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("RESET_VECTOR must be word aligned");
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   r_delay_pending;
  logic   w_delay_nxt;
  logic   w_is_load;
  logic   w_is_store;
  logic   w_writes_reg;
  logic   w_redirect;

  mips_cpu_ctrl_class u_class (
    .i_opcode     (opcode),
    .i_funccode   (funccode),
    .i_rt         (rt),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_writes_reg (w_writes_reg)
  );

  assign w_redirect = is_jump || (is_branch && cond_met);
  assign state      = r_state;

  // State register and delay-slot flag
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      r_state         <= FETCH;
      r_delay_pending <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_delay_pending <= w_delay_nxt;
    end
  end

  // Next-state and strobe decode from the registered state
  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay_pending;
    active      = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = ADDR_SEL_PC;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    target_load = 1'b0;
    reg_write   = 1'b0;

    case (r_state)
      FETCH: begin
        if (pc_is_zero) begin
          // PC reached the halt address: stop without touching the bus
          w_state_nxt = HALTED;
        end else begin
          mem_read = 1'b1;
          addr_sel = ADDR_SEL_PC;
          if (!waitrequest) begin
            ir_write    = 1'b1;
            w_state_nxt = DECODE;
          end
        end
      end

      DECODE: begin
        w_state_nxt = EXEC;
      end

      EXEC: begin
        pc_write = 1'b1;
        pc_src   = r_delay_pending ? PC_SRC_TARGET : PC_SRC_SEQ;
        if (r_delay_pending) begin
          // Delay-slot instruction: apply the pending target, ignore any
          // redirect of its own
          w_delay_nxt = 1'b0;
        end else if (w_redirect) begin
          target_load = 1'b1;
          w_delay_nxt = 1'b1;
        end

        if (w_is_load || w_is_store) begin
          w_state_nxt = MEM;
        end else if (w_writes_reg) begin
          w_state_nxt = WB;
        end else begin
          w_state_nxt = FETCH;
        end
      end

      MEM: begin
        addr_sel  = ADDR_SEL_ALU;
        mem_read  = w_is_load;
        mem_write = w_is_store && !w_is_load;
        if (!waitrequest) begin
          w_state_nxt = w_is_load ? WB : FETCH;
        end
      end

      WB: begin
        reg_write   = 1'b1;
        w_state_nxt = FETCH;
      end

      HALTED: begin
        active      = 1'b0;
        w_state_nxt = HALTED;
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase

    // The registered state is already FETCH during reset, so the FETCH decode
    // above would raise mem_read/ir_write; hold every strobe low instead.
    if (!reset_n) begin
      active      = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_sel    = ADDR_SEL_PC;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_SRC_SEQ;
      target_load = 1'b0;
      reg_write   = 1'b0;
    end
  end

  // The bus never sees a read and a write together
  a_rw_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_read && mem_write));

  // Register writes only ever come from the write-back state
  a_wb_only : assert property (@(posedge clk) disable iff (!reset_n)
    reg_write |-> (r_state == WB));

endmodule : mips_cpu_ctrl_fsm
